// File: rtl/eae_muldiv_pkg.sv
// ============================================================================
// eae_muldiv_pkg : shared types for the EAE multiply/divide engine
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package eae_muldiv_pkg;

  typedef enum logic {
    EAE_MUY = 1'b0,
    EAE_DVI = 1'b1
  } eae_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } eae_state_t;

endpackage

`default_nettype wire

// File: rtl/eae_step.sv
// ============================================================================
// eae_step : one shift-add multiply or restoring-divide iteration
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module eae_step
  import eae_muldiv_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  eae_op_t          op_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] y_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  always_comb begin
    // Multiply: lo holds the multiplier LSB-first, y the multiplicand.
    w_sum   = {1'b0, hi_i} + (lo_i[0] ? {1'b0, y_i} : '0);
    // Divide: the shifted remainder needs one spare bit before the compare.
    w_shift = {hi_i, lo_i[WIDTH-1]};
    w_ge    = (w_shift >= {1'b0, y_i});
    w_diff  = w_shift[WIDTH-1:0] - y_i;
    if (op_i == EAE_DVI) begin
      hi_o = w_ge ? w_diff : w_shift[WIDTH-1:0];
      lo_o = {lo_i[WIDTH-2:0], w_ge};
    end else begin
      hi_o = w_sum[WIDTH:1];
      lo_o = {w_sum[0], lo_i[WIDTH-1:1]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/eae_muldiv.sv
// ============================================================================
// eae_muldiv : PDP-8 EAE MUY/DVI engine, one bit per clock
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module eae_muldiv
  import eae_muldiv_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             op_i,
  input  logic [WIDTH-1:0] ac_i,
  input  logic [WIDTH-1:0] mq_i,
  input  logic [WIDTH-1:0] operand_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] ac_o,
  output logic [WIDTH-1:0] mq_o,
  output logic             link_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  eae_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] ac_q, ac_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic             link_q, link_d;

  eae_op_t          w_step_op;
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;

  assign w_step_op = (state_q == DIV) ? EAE_DVI : EAE_MUY;

  eae_step #(.WIDTH(WIDTH)) u_step (
    .op_i (w_step_op),
    .hi_i (hi_q),
    .lo_i (lo_q),
    .y_i  (y_q),
    .hi_o (w_hi),
    .lo_o (w_lo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    y_d     = y_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ac_d    = ac_q;
    mq_d    = mq_q;
    link_d  = link_q;
    case (state_q)
      IDLE: begin
        // busy_q is still high during the done cycle, which blocks a relaunch.
        busy_d = 1'b0;
        if (start_i && !abort_i && !busy_q) begin
          busy_d = 1'b1;
          cnt_d  = CNT_W'(WIDTH);
          hi_d   = ac_i;
          ovf_d  = 1'b0;
          if (op_i == EAE_MUY) begin
            lo_d    = operand_i;
            y_d     = mq_i;
            state_d = MUL;
          end else begin
            lo_d = mq_i;
            y_d  = operand_i;
            if (ac_i >= operand_i) begin
              ovf_d   = 1'b1;
              state_d = DONE;
            end else begin
              state_d = DIV;
            end
          end
        end
      end
      MUL, DIV: begin
        if (abort_i) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          hi_d  = w_hi;
          lo_d  = w_lo;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        if (abort_i) begin
          busy_d = 1'b0;
        end else begin
          ac_d   = hi_q;
          mq_d   = lo_q;
          link_d = ovf_q;
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      y_q     <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ac_q    <= '0;
      mq_q    <= '0;
      link_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      y_q     <= y_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ac_q    <= ac_d;
      mq_q    <= mq_d;
      link_q  <= link_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign ac_o   = ac_q;
  assign mq_o   = mq_q;
  assign link_o = link_q;

endmodule

`default_nettype wire

// File: tb/tb_eae_muldiv.sv
// ============================================================================
// tb_eae_muldiv : scoreboard bench for eae_muldiv (WIDTH=12 plus a WIDTH=16 build)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_eae_muldiv;

  localparam int W = 12;
  localparam int V = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0, op = 1'b0, abort = 1'b0;
  logic [W-1:0] ac_in = '0, mq_in = '0, y_in = '0;
  logic         busy, done, link;
  logic [W-1:0] ac_out, mq_out;

  logic         start16 = 1'b0;
  logic [V-1:0] ac16_in = '0, mq16_in = '0, y16_in = '0;
  logic         busy16, done16, link16;
  logic [V-1:0] ac16_out, mq16_out;

  always #5 clk = ~clk;

  eae_muldiv #(.WIDTH(W)) dut (
    .clock_i(clk), .reset_i(rst), .start_i(start), .op_i(op),
    .ac_i(ac_in), .mq_i(mq_in), .operand_i(y_in), .abort_i(abort),
    .busy_o(busy), .done_o(done), .ac_o(ac_out), .mq_o(mq_out), .link_o(link)
  );

  eae_muldiv #(.WIDTH(V)) dut16 (
    .clock_i(clk), .reset_i(rst), .start_i(start16), .op_i(1'b0),
    .ac_i(ac16_in), .mq_i(mq16_in), .operand_i(y16_in), .abort_i(1'b0),
    .busy_o(busy16), .done_o(done16), .ac_o(ac16_out), .mq_o(mq16_out), .link_o(link16)
  );

  typedef struct {
    logic [W-1:0] ac;
    logic [W-1:0] mq;
    logic         link;
    int           due;
    string        tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference: plain integer arithmetic on the architectural values.
  function automatic exp_t model(input logic o, input logic [W-1:0] a, m, y);
    exp_t e;
    logic [63:0] p;
    e.tag = "";
    if (!o) begin
      p = 64'(m) * 64'(y) + 64'(a);
      e.ac = W'(p >> W); e.mq = W'(p); e.link = 1'b0; e.due = W + 1;
    end else if (a >= y) begin
      e.ac = a; e.mq = m; e.link = 1'b1; e.due = 1;
    end else begin
      p = (64'(a) << W) | 64'(m);
      e.mq = W'(p / 64'(y)); e.ac = W'(p % 64'(y)); e.link = 1'b0; e.due = W + 1;
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.tag, "_ac"}, 64'(ac_out), 64'(e.ac));
        chk({e.tag, "_mq"}, 64'(mq_out), 64'(e.mq));
        chk({e.tag, "_link"}, 64'(link), 64'(e.link));
        chk({e.tag, "_latency"}, 64'(cyc), 64'(e.due));
        chk({e.tag, "_busy_at_done"}, 64'(busy), 64'd1);
        last_exp = e;
      end
    end
  end

  task automatic launch(input logic o, input logic [W-1:0] a, m, y, input string tag);
    exp_t e;
    @(negedge clk);
    op = o; ac_in = a; mq_in = m; y_in = y; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e = model(o, a, m, y);
    e.tag = tag;
    e.due = cyc + e.due;
    exp_q.push_back(e);
    // Inputs after launch must not influence the result.
    op = 1'($urandom); ac_in = W'($urandom); mq_in = W'($urandom); y_in = W'($urandom);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      chk({tag, "_timeout"}, 64'd0, 64'd1);
      exp_q.delete();
    end
    @(negedge clk);
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] a, m, y;
    logic         o;
    int           k;
    logic         got;

    last_exp.ac = '0; last_exp.mq = '0; last_exp.link = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_ac", 64'(ac_out), 64'd0);
    chk("reset_mq", 64'(mq_out), 64'd0);
    chk("reset_link", 64'(link), 64'd0);
    chk("reset16_ac", 64'(ac16_out), 64'd0);
    chk("reset16_mq", 64'(mq16_out), 64'd0);
    rst = 1'b0;

    launch(1'b0, 12'o0000, 12'o0003, 12'o0005, "muy_3x5");      wait_idle("muy_3x5");
    launch(1'b0, 12'o7777, 12'o7777, 12'o7777, "muy_max");      wait_idle("muy_max");
    launch(1'b1, 12'o0000, 12'o0144, 12'o0007, "dvi_100_7");    wait_idle("dvi_100_7");
    launch(1'b1, 12'o0005, 12'o1234, 12'o0005, "dvi_ovf_eq");   wait_idle("dvi_ovf_eq");
    launch(1'b1, 12'o0005, 12'o4321, 12'o0000, "dvi_ovf_zero"); wait_idle("dvi_ovf_zero");

    for (int i = 0; i < 40; i++) begin
      o = 1'($urandom); a = W'($urandom); m = W'($urandom); y = W'($urandom);
      if (o && y != 0 && ($urandom % 8) != 0) a = a % y;
      launch(o, a, m, y, o ? "rnd_dvi" : "rnd_muy");
      wait_idle("rnd");
    end

    // Second start while busy is ignored: one done, original result.
    launch(1'b0, 12'o1234, 12'o4567, 12'o0321, "muy_restart");
    repeat (3) @(posedge clk);
    @(negedge clk);
    op = 1'b1; ac_in = 12'o0001; mq_in = 12'o0002; y_in = 12'o0003; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_idle("muy_restart");
    repeat (20) @(negedge clk);

    // Abort mid-divide keeps previous outputs and produces no done.
    launch(1'b1, 12'o0012, 12'o3456, 12'o0077, "dvi_abort");
    repeat (5) @(posedge clk);
    @(negedge clk); abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    exp_q.delete();
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_ac_hold", 64'(ac_out), 64'(last_exp.ac));
    chk("abort_mq_hold", 64'(mq_out), 64'(last_exp.mq));
    repeat (20) @(negedge clk);

    // Abort while in the overflow DONE cycle.
    launch(1'b1, 12'o0007, 12'o0001, 12'o0003, "ovf_abort");
    abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    exp_q.delete();
    chk("ovf_abort_busy", 64'(busy), 64'd0);
    chk("ovf_abort_link_hold", 64'(link), 64'(last_exp.link));
    repeat (20) @(negedge clk);

    // start with abort in IDLE: stays idle.
    @(negedge clk); op = 1'b0; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1; start = 1'b0; abort = 1'b0;
    chk("start_abort_idle_busy", 64'(busy), 64'd0);
    repeat (20) @(negedge clk);

    // Restart at iteration 4, reset at iteration 7, then a normal divide.
    launch(1'b0, 12'o0123, 12'o0456, 12'o0701, "muy_reset");
    repeat (3) @(posedge clk);
    @(negedge clk); op = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    exp_q.delete();
    #1;
    chk("midreset_busy", 64'(busy), 64'd0);
    chk("midreset_done", 64'(done), 64'd0);
    chk("midreset_ac", 64'(ac_out), 64'd0);
    chk("midreset_mq", 64'(mq_out), 64'd0);
    chk("midreset_link", 64'(link), 64'd0);
    @(negedge clk); rst = 1'b0;
    launch(1'b1, 12'o0000, 12'o0144, 12'o0007, "dvi_after_reset");
    wait_idle("dvi_after_reset");

    // WIDTH=16 build.
    @(negedge clk);
    ac16_in = 16'h0000; mq16_in = 16'hFFFF; y16_in = 16'h0002; start16 = 1'b1;
    @(posedge clk); #1; start16 = 1'b0;
    k = 0; got = 1'b0;
    while (!got && k < 40) begin
      @(posedge clk); k++;
      @(negedge clk);
      if (done16) got = 1'b1;
    end
    chk("w16_done_seen", 64'(got), 64'd1);
    chk("w16_latency", 64'(k), 64'd17);
    chk("w16_ac", 64'(ac16_out), 64'h0001);
    chk("w16_mq", 64'(mq16_out), 64'hFFFE);
    chk("w16_link", 64'(link16), 64'd0);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/eae_muldiv.md
Name: eae_muldiv

Overview:
- Parametrised multi-cycle multiply/divide engine for the PDP-8 Extended Arithmetic Element (MUY and DVI instructions).
- Replaces the stubbed EAE datapath.
- Operates on AC, MQ and a memory operand of WIDTH bits, using iterative shift-add multiply and restoring divide, one bit per clock.
- The CPU launches an operation with a start pulse, waits on busy, and latches ac_out/mq_out/link_out when done pulses.

Parameters:
- WIDTH, 12: data width of AC, MQ and operand. Legal range 4..32.
- CNT_W, $clog2(WIDTH+1): iteration counter width. Derived; do not override.

Ports:
- clock, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- start, input, 1: launch request, sampled only in IDLE.
- op, input, 1: 0 = MUY, 1 = DVI.
- ac_in, input, WIDTH: AC at launch (MUY addend; DVI dividend high half).
- mq_in, input, WIDTH: MQ at launch (MUY multiplicand; DVI dividend low half).
- operand, input, WIDTH: memory word Y (multiplier or divisor).
- abort, input, 1: synchronous cancel; returns to IDLE without done.
- busy, output, 1: operation in progress.
- done, output, 1: one-cycle pulse when results are valid.
- ac_out, output, WIDTH: MUY product high half; DVI remainder.
- mq_out, output, WIDTH: MUY product low half; DVI quotient.
- link_out, output, 1: DVI overflow flag. Always 0 for MUY.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, busy=0, done=0, ac_out=0, mq_out=0, link_out=0, counter=0, internal registers=0. Reset asserted mid-operation aborts it immediately, with no done pulse.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - On start=1 at edge E0, latch the inputs and set busy=1.
  - op=0 goes to MUL.
  - op=1 with ac_in >= operand (overflow; includes operand=0) goes straight to DONE with link_out=1 and ac_out/mq_out = ac_in/mq_in unchanged.
  - Otherwise op=1 goes to DIV.
- MUL:
  - Accumulator {P_hi, P_lo} initialised to {ac_in, mq_in}-style shift-add.
  - Result is exactly mq_in*operand + ac_in as an unsigned 2*WIDTH-bit value. It cannot overflow.
  - One multiplier bit per clock, WIDTH iterations, then DONE.
  - High half goes to ac_out, low half to mq_out, and link_out=0.
- DIV:
  - Unsigned restoring divide of {ac_in, mq_in} by operand, one quotient bit per clock, WIDTH iterations, then DONE.
  - Partial remainder is WIDTH+1 bits wide to hold the shifted-out bit.
  - Quotient goes to mq_out, remainder to ac_out, and link_out=0.
- DONE:
  - done=1 for exactly one cycle. busy is still 1 in that cycle.
  - Next state is IDLE. busy falls together with done.
- Latency:
  - Normal: done is high in the cycle after edge E(WIDTH+1), i.e. WIDTH+1 clocks after start is sampled.
  - Overflow: done is high in the cycle after edge E1.
- Output holding: ac_out, mq_out and link_out are registered and hold until the next completed operation. They are not disturbed during iteration; working registers are separate.
- start while busy=1: ignored, with no queuing.
- start and abort together in IDLE: abort wins, and the block stays IDLE.
- abort in MUL, DIV or DONE: next state is IDLE, busy=0, done=0, outputs keep their previous values.
- All arithmetic is unsigned. No input changes after E0 affect the result.

Decomposition:
- Shared package (CPU_Definitions.pkg):
  - eae_op_t enum {EAE_MUY=1'b0, EAE_DVI=1'b1}.
  - eae_state_t enum {IDLE, MUL, DIV, DONE}.
- Sub-module eae_step: combinational single-iteration datapath, parametrised by WIDTH. Takes op, the working registers and the operand bit/divisor, and returns the next working registers.
- eae_muldiv contains the FSM, counter and registers, and instantiates eae_step once.

Test Plan (WIDTH=12 unless noted, values octal):
- MUY with ac_in=0000, mq_in=0003, operand=0005 -> done 13 clocks after start; ac_out=0000, mq_out=0017, link_out=0.
- MUY with ac_in=7777, mq_in=7777, operand=7777 -> ac_out=7777, mq_out=0000, link_out=0 (checks the addend carry).
- DVI with ac_in=0000, mq_in=0144, operand=0007 -> mq_out=0016, ac_out=0002, link_out=0, done 13 clocks after start.
- DVI with ac_in=0005, operand=0005, and again with operand=0000 -> done 1 clock after start; link_out=1; ac_out/mq_out equal to the inputs.
- Start pulsed again at iteration 4, then reset asserted at iteration 7 of a MUY -> second start ignored; after reset all outputs are 0, busy=0 and no done pulse. A following DVI completes normally.
- WIDTH=16 build, MUY with mq_in=FFFF(hex), operand=0002, ac_in=0 -> ac_out=0001, mq_out=FFFE, done 17 clocks after start.
